// File: rtl/re_name_retire_if.sv
// Issue/commit/restore signal bundle between the re-namer, commit stage and retire tracker.
interface re_name_retire_if #(
  parameter int ISSUE_WIDTH     = 1,
  parameter int NR_COMMIT_PORTS = 2
);
  logic                                  flush_i;
  logic [ISSUE_WIDTH-1:0]                issue_ack_i;
  logic [ISSUE_WIDTH-1:0][5:0]           issue_rd_i;
  logic [ISSUE_WIDTH-1:0]                issue_rd_fpr_i;
  logic [ISSUE_WIDTH-1:0]                issue_stall_o;
  logic [NR_COMMIT_PORTS-1:0]            commit_valid_i;
  logic [NR_COMMIT_PORTS-1:0][5:0]       commit_rd_i;
  logic [NR_COMMIT_PORTS-1:0]            commit_rd_fpr_i;
  logic [NR_COMMIT_PORTS-1:0]            commit_ack_o;
  logic                                  restore_valid_o;
  logic [31:0]                           restore_gpr_o;
  logic [31:0]                           restore_fpr_o;
  logic                                  restore_ack_i;
  logic                                  name_error_o;

  modport slave (
    input  flush_i, issue_ack_i, issue_rd_i, issue_rd_fpr_i,
           commit_valid_i, commit_rd_i, commit_rd_fpr_i, restore_ack_i,
    output issue_stall_o, commit_ack_o, restore_valid_o,
           restore_gpr_o, restore_fpr_o, name_error_o
  );

  modport master (
    output flush_i, issue_ack_i, issue_rd_i, issue_rd_fpr_i,
           commit_valid_i, commit_rd_i, commit_rd_fpr_i, restore_ack_i,
    input  issue_stall_o, commit_ack_o, restore_valid_o,
           restore_gpr_o, restore_fpr_o, name_error_o
  );
endinterface

// File: rtl/re_name_retire.sv
// Commit-side name tracker: committed name bits, in-flight rename bitmap, flush restore handshake.
module re_name_retire #(
  parameter int ISSUE_WIDTH     = 1,
  parameter int NR_COMMIT_PORTS = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  re_name_retire_if.slave    bus
);

  typedef enum logic {IDLE, RESTORE} state_e;

  state_e           state_q, state_d;
  logic [1:0][31:0] comm_q, comm_d;   // [0]=GPR, [1]=FPR
  logic [1:0][31:0] outs_q, outs_d;
  logic             err_q, err_d;

  logic [ISSUE_WIDTH-1:0]     stall;
  logic [NR_COMMIT_PORTS-1:0] cack;
  logic                       rvalid;

  always_comb begin
    logic       f;
    logic [4:0] a;
    logic       x0;
    state_d = state_q;
    comm_d  = comm_q;
    outs_d  = outs_q;
    err_d   = err_q;
    stall   = '0;
    cack    = '0;
    rvalid  = 1'b0;
    f       = 1'b0;
    a       = '0;
    x0      = 1'b0;

    // Stall uses registered outstanding state only; never looks at issue_ack_i.
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      f  = bus.issue_rd_fpr_i[i];
      a  = bus.issue_rd_i[i][4:0];
      x0 = !f && (a == 5'd0);
      stall[i] = (state_q == RESTORE) || bus.flush_i || (outs_q[f][a] && !x0);
      for (int j = 0; j < i; j++) begin
        if (!x0 && !stall[j] && (bus.issue_rd_fpr_i[j] == f) &&
            (bus.issue_rd_i[j][4:0] == a))
          stall[i] = 1'b1;
      end
    end

    if (state_q == IDLE) begin
      // Ascending port order: the highest index commit wins a shared entry.
      for (int c = 0; c < NR_COMMIT_PORTS; c++) begin
        if (bus.commit_valid_i[c]) begin
          cack[c] = 1'b1;
          f  = bus.commit_rd_fpr_i[c];
          a  = bus.commit_rd_i[c][4:0];
          x0 = !f && (a == 5'd0);
          if (!x0) begin
            if (bus.commit_rd_i[c][5] == comm_q[f][a]) err_d = 1'b1;
            comm_d[f][a] = bus.commit_rd_i[c][5];
            outs_d[f][a] = 1'b0;
          end
        end
      end
      if (bus.flush_i) begin
        outs_d  = '0;
        state_d = RESTORE;
      end else begin
        // Applied after commit clears so a same-cycle rename of the register survives.
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
          f  = bus.issue_rd_fpr_i[i];
          a  = bus.issue_rd_i[i][4:0];
          x0 = !f && (a == 5'd0);
          if (bus.issue_ack_i[i] && !x0) outs_d[f][a] = 1'b1;
        end
      end
    end else begin
      rvalid = 1'b1;
      if (bus.restore_ack_i) state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      comm_q  <= '0;
      outs_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      comm_q  <= comm_d;
      outs_q  <= outs_d;
      err_q   <= err_d;
    end
  end

  assign bus.issue_stall_o   = stall;
  assign bus.commit_ack_o    = cack;
  assign bus.restore_valid_o = rvalid;
  assign bus.restore_gpr_o   = {comm_q[0][31:1], 1'b0};
  assign bus.restore_fpr_o   = comm_q[1];
  assign bus.name_error_o    = err_q;

endmodule
